seg7_scan_ctrl: RTL and testbench

Parametrised multiplexed seven-segment display controller: scans NUM_DIGITS hex digits at a programmable slot rate, with per-digit decimal points, per-digit blanking, PWM brightness and tear-free frame-synchronous data updates. It sits between the CPU/MMIO debug register and the board display pins. It is the general-purpose replacement for the fixed 8-digit scanner, and is usable on both the 100 MHz and 50 MHz boards through SCAN_DIV.

---
 rtl/seg7_scan_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: multiplexed seven-segment display scanner.
// Scans NUM_DIGITS hex digits, one slot of SCAN_DIV clocks per digit, with
// per-digit decimal point and blanking, PWM brightness and a double-buffered
// (pending/display) register set that only changes at frame boundaries.
// Optional feature macro: SEG7_LZ_BLANK_EN (leading-zero suppression).
module seg7_scan_ctrl #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int BRIGHT_W   = 4,
    parameter int ACTIVE_LOW = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    input  logic [BRIGHT_W-1:0]     brightness,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              cathode,
    output logic                    dp,
    output logic                    frame_done
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    // Level of every pin when it is not driving anything.
    localparam logic INACT = (ACTIVE_LOW != 0);

    // Hex glyph, active-high, bit0 = a ... bit6 = g.
    function automatic logic [6:0] seg_hi(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

`ifdef SEG7_LZ_BLANK_EN
    // Clears enables of digits above the most-significant enabled non-zero
    // nibble; digit 0 always keeps its own enable.
    function automatic logic [NUM_DIGITS-1:0] lz_mask(
        input logic [4*NUM_DIGITS-1:0] d,
        input logic [NUM_DIGITS-1:0]   en
    );
        logic [NUM_DIGITS-1:0] m;
        logic                  seen;
        m    = en;
        seen = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (en[i] && (d[4*i +: 4] != 4'h0)) seen = 1'b1;
            if (!seen) m[i] = 1'b0;
        end
        return m;
    endfunction
`endif

    // Scan timing state
    logic [DIV_W-1:0]    div_cnt;
    logic [IDX_W-1:0]    scan_idx;
    logic [BRIGHT_W-1:0] pwm_cnt;
    logic                slot_end;
    logic                frame_tick;

    // Register sets
    logic [4*NUM_DIGITS-1:0] pend_data;
    logic [NUM_DIGITS-1:0]   pend_dp;
    logic [NUM_DIGITS-1:0]   pend_en;
    logic [4*NUM_DIGITS-1:0] disp_data;
    logic [NUM_DIGITS-1:0]   disp_dp;
    logic [NUM_DIGITS-1:0]   disp_en;

    // Values the display set takes at a frame boundary
    logic [4*NUM_DIGITS-1:0] src_data;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [NUM_DIGITS-1:0]   src_en;
    logic [NUM_DIGITS-1:0]   src_en_eff;

    // Current-slot selection and pin next-state
    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_en;
    logic [NUM_DIGITS-1:0] slot_hit;
    logic                  pwm_on;
    logic                  lit;
    logic [NUM_DIGITS-1:0] anode_nxt;
    logic [6:0]            cathode_nxt;
    logic                  dp_nxt;

    // Registered pins
    logic [NUM_DIGITS-1:0] anode_p1;
    logic [6:0]            cathode_p1;
    logic                  dp_p1;
    logic                  frame_done_p1;

    assign slot_end   = (div_cnt == DIV_LAST);
    assign frame_tick = slot_end && (scan_idx == IDX_LAST);

    // Slot divider, digit index and free-running PWM phase counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt  <= '0;
            scan_idx <= '0;
            pwm_cnt  <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            div_cnt <= slot_end ? '0 : div_cnt + 1'b1;
            if (slot_end) begin
                scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
            end
        end
    end

    // A load landing on the frame boundary bypasses pending straight into display.
    always_comb begin
        src_data = load ? data     : pend_data;
        src_dp   = load ? dp_in    : pend_dp;
        src_en   = load ? digit_en : pend_en;
`ifdef SEG7_LZ_BLANK_EN
        src_en_eff = lz_mask(src_data, src_en);
`else
        src_en_eff = src_en;
`endif
    end

    // Pending captures every load; display only changes on the frame boundary.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_data <= '0;
            pend_dp   <= '0;
            pend_en   <= '0;
            disp_data <= '0;
            disp_dp   <= '0;
            disp_en   <= '0;
        end else begin
            if (load) begin
                pend_data <= data;
                pend_dp   <= dp_in;
                pend_en   <= digit_en;
            end
            if (frame_tick) begin
                disp_data <= src_data;
                disp_dp   <= src_dp;
                disp_en   <= src_en_eff;
            end
        end
    end

    // Pick the nibble, dp and enable of the digit owning the current slot.
    always_comb begin
        sel_nib  = 4'h0;
        sel_dp   = 1'b0;
        sel_en   = 1'b0;
        slot_hit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_idx == IDX_W'(i)) begin
                sel_nib     = disp_data[4*i +: 4];
                sel_dp      = disp_dp[i];
                sel_en      = disp_en[i];
                slot_hit[i] = 1'b1;
            end
        end
    end

    assign pwm_on = (pwm_cnt <= brightness);
    assign lit    = sel_en && pwm_on;

    // Build active-high pin values, then fold in the board polarity.
    always_comb begin
        anode_nxt   = (lit ? slot_hit : '0) ^ {NUM_DIGITS{INACT}};
        cathode_nxt = (lit ? seg_hi(sel_nib) : 7'h00) ^ {7{INACT}};
        dp_nxt      = (lit & sel_dp) ^ INACT;
    end

    // Output registers: pins lag the scan state by one clock.
    always_ff @(posedge clk) begin
        if (reset) begin
            anode_p1      <= {NUM_DIGITS{INACT}};
            cathode_p1    <= {7{INACT}};
            dp_p1         <= INACT;
            frame_done_p1 <= 1'b0;
        end else begin
            anode_p1      <= anode_nxt;
            cathode_p1    <= cathode_nxt;
            dp_p1         <= dp_nxt;
            frame_done_p1 <= frame_tick;
        end
    end

    assign anode      = anode_p1;
    assign cathode    = cathode_p1;
    assign dp         = dp_p1;
    assign frame_done = frame_done_p1;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Testbench for seg7_scan_ctrl (NUM_DIGITS=8, SCAN_DIV=16, BRIGHT_W=4,
// active-low pins). Every cycle the expected pins are pushed to a queue as
// inputs are driven and popped/compared after the clock edge; a vector table
// plus hand-written sequences check frame-level behaviour.
module tb_seg7_scan_ctrl;

    localparam int N  = 8;
    localparam int S  = 16;
    localparam int FR = N * S;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] data = '0;
    logic [7:0]  dp_in = '0;
    logic [7:0]  digit_en = '0;
    logic        load = 1'b0;
    logic [3:0]  brightness = '0;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_done;

    seg7_scan_ctrl #(
        .NUM_DIGITS(N),
        .SCAN_DIV  (S),
        .BRIGHT_W  (4),
        .ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .data      (data),
        .dp_in     (dp_in),
        .digit_en  (digit_en),
        .load      (load),
        .brightness(brightness),
        .anode     (anode),
        .cathode   (cathode),
        .dp        (dp),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: time since reset plus the two register sets
    int          t = 0;
    logic [31:0] m_pend_data = '0;
    logic [7:0]  m_pend_dp = '0;
    logic [7:0]  m_pend_en = '0;
    logic [31:0] m_disp_data = '0;
    logic [7:0]  m_disp_dp = '0;
    logic [7:0]  m_disp_en = '0;

    logic [16:0] sbq[$];

    // Pins seen after the latest step, and per-window statistics
    logic [7:0] last_an;
    logic [6:0] last_cath;
    logic       last_dp;
    logic       last_fd = 1'b0;
    int         an_cnt = 0;
    int         dp_cnt = 0;

    typedef struct {
        logic [31:0] d;
        logic [7:0]  dpi;
        logic [7:0]  en;
        logic [3:0]  br;
        int          exp_an;
        int          exp_dp;
        logic [6:0]  exp_c0;
    } vec_t;

    vec_t vecs[5];

    // Active-low glyphs, bit0 = a ... bit6 = g
    function automatic logic [6:0] glyph_al(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;  4'h1: g = 7'h79;  4'h2: g = 7'h24;  4'h3: g = 7'h30;
            4'h4: g = 7'h19;  4'h5: g = 7'h12;  4'h6: g = 7'h02;  4'h7: g = 7'h78;
            4'h8: g = 7'h00;  4'h9: g = 7'h10;  4'hA: g = 7'h08;  4'hB: g = 7'h03;
            4'hC: g = 7'h46;  4'hD: g = 7'h21;  4'hE: g = 7'h06;  default: g = 7'h0E;
        endcase
        return g;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    endtask

    // One clock: predict pins, push, clock, advance model, pop and compare.
    task automatic step();
        logic [16:0] e;
        logic [16:0] q;
        logic [7:0]  an_e;
        logic [6:0]  c_e;
        logic        dp_e;
        logic        fd_e;
        logic        on;
        int          idx;
        int          pw;
        int          tb;
        tb = t;
        if (reset) begin
            an_e = 8'hFF; c_e = 7'h7F; dp_e = 1'b1; fd_e = 1'b0;
        end else begin
            idx  = (t / S) % N;
            pw   = t % 16;
            on   = m_disp_en[idx] && (pw <= int'(brightness));
            an_e = on ? 8'(~(8'b1 << idx)) : 8'hFF;
            c_e  = on ? glyph_al(m_disp_data[4*idx +: 4]) : 7'h7F;
            dp_e = on ? ~m_disp_dp[idx] : 1'b1;
            fd_e = ((t % FR) == FR - 1);
        end
        e = {an_e, c_e, dp_e, fd_e};
        sbq.push_back(e);
        @(posedge clk);
        if (reset) begin
            t = 0;
            m_pend_data = '0; m_pend_dp = '0; m_pend_en = '0;
            m_disp_data = '0; m_disp_dp = '0; m_disp_en = '0;
        end else begin
            if ((t % FR) == FR - 1) begin
                m_disp_data = load ? data     : m_pend_data;
                m_disp_dp   = load ? dp_in    : m_pend_dp;
                m_disp_en   = load ? digit_en : m_pend_en;
`ifdef SEG7_LZ_BLANK_EN
                begin
                    bit seen;
                    seen = 1'b0;
                    for (int i = 7; i >= 1; i--) begin
                        if (m_disp_en[i] && (m_disp_data[4*i +: 4] != 4'h0)) seen = 1'b1;
                        if (!seen) m_disp_en[i] = 1'b0;
                    end
                end
`endif
            end
            if (load) begin
                m_pend_data = data; m_pend_dp = dp_in; m_pend_en = digit_en;
            end
            t++;
        end
        #1;
        q = sbq.pop_front();
        check($sformatf("pins t=%0d {an,cath,dp,fd}", tb), 32'({anode, cathode, dp, frame_done}), 32'(q));
        last_an   = anode;
        last_cath = cathode;
        last_dp   = dp;
        last_fd   = frame_done;
        if (anode != 8'hFF) an_cnt++;
        if (dp == 1'b0) dp_cnt++;
    endtask

    // Step until the next step's edge is the frame boundary.
    task automatic run_to_boundary();
        while ((t % FR) != FR - 1) step();
    endtask

    // Step until frame_done is seen on the pins, bounded.
    task automatic wait_fd(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (last_fd !== 1'b1 && n < 3 * FR);
        check({name, " frame_done seen"}, 32'(last_fd), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [6:0] c0;

        // {data, dp_in, digit_en, brightness, anode-active clocks/frame, dp clocks/frame, digit-0 cathode}
`ifdef SEG7_LZ_BLANK_EN
        vecs[0] = '{32'h0000_00A5, 8'h00, 8'hFF, 4'hF, 32, 0, 7'h12};
        vecs[4] = '{32'h0000_0003, 8'h0F, 8'h0F, 4'h7, 8, 8, 7'h30};
`else
        vecs[0] = '{32'h0000_00A5, 8'h00, 8'hFF, 4'hF, 128, 0, 7'h12};
        vecs[4] = '{32'h0000_0003, 8'h0F, 8'h0F, 4'h7, 32, 32, 7'h30};
`endif
        vecs[1] = '{32'h1234_5678, 8'h01, 8'hFF, 4'h3, 32, 4, 7'h00};
        vecs[2] = '{32'h89AB_CDEF, 8'h80, 8'h7F, 4'hF, 112, 0, 7'h0E};
        vecs[3] = '{32'hFFFF_FFF0, 8'hFF, 8'h01, 4'h0, 1, 1, 7'h40};

        // Reset state
        reset = 1'b1;
        repeat (3) step();
        check("reset anode", 32'(last_an), 32'hFF);
        check("reset cathode", 32'(last_cath), 32'h7F);
        check("reset dp", 32'(last_dp), 32'h1);
        check("reset frame_done", 32'(last_fd), 32'h0);
        reset = 1'b0;

        // First frame: dark until the first frame_done, then A5 appears
        data = 32'h0000_00A5; dp_in = 8'h00; digit_en = 8'hFF; brightness = 4'hF;
        an_cnt = 0;
        load = 1'b1; step(); load = 1'b0;
        wait_fd("first", n);
        check("first frame_done clock", 32'(n + 1), 32'(FR));
        check("dark before first frame_done", 32'(an_cnt), 32'd0);
        step();
        check("digit0 anode", 32'(last_an), 32'hFE);
        check("digit0 cathode", 32'(last_cath), 32'h12);
        repeat (S) step();
        check("digit1 anode", 32'(last_an), 32'hFD);
        check("digit1 cathode", 32'(last_cath), 32'h08);
        repeat (S) step();
`ifdef SEG7_LZ_BLANK_EN
        check("digit2 anode", 32'(last_an), 32'hFF);
        check("digit2 cathode", 32'(last_cath), 32'h7F);
`else
        check("digit2 anode", 32'(last_an), 32'hFB);
        check("digit2 cathode", 32'(last_cath), 32'h40);
`endif

        // Mid-frame load: old data until frame_done, new data right after
        repeat (S) step();
        data = 32'h1234_5678;
        load = 1'b1; step(); load = 1'b0;
        wait_fd("midframe", n);
`ifdef SEG7_LZ_BLANK_EN
        check("midframe last slot old cathode", 32'(last_cath), 32'h7F);
`else
        check("midframe last slot old cathode", 32'(last_cath), 32'h40);
        check("midframe last slot old anode", 32'(last_an), 32'h7F);
`endif
        step();
        check("midframe new digit0 anode", 32'(last_an), 32'hFE);
        check("midframe new digit0 cathode", 32'(last_cath), 32'h00);

        // Table: load on the frame boundary, measure the following frame
        for (int v = 0; v < 5; v++) begin
            run_to_boundary();
            data = vecs[v].d; dp_in = vecs[v].dpi; digit_en = vecs[v].en; brightness = vecs[v].br;
            load = 1'b1; step(); load = 1'b0;
            an_cnt = 0; dp_cnt = 0;
            step();
            c0 = last_cath;
            repeat (FR - 1) step();
            check($sformatf("vec%0d anode-active clocks", v), 32'(an_cnt), 32'(vecs[v].exp_an));
            check($sformatf("vec%0d dp-active clocks", v), 32'(dp_cnt), 32'(vecs[v].exp_dp));
            check($sformatf("vec%0d digit0 cathode", v), 32'(c0), 32'(vecs[v].exp_c0));
        end

        // Reset for one cycle in slot 5, then scanning restarts at digit 0
        run_to_boundary();
        data = 32'h1234_5678; dp_in = 8'h00; digit_en = 8'hFF; brightness = 4'hF;
        load = 1'b1; step(); load = 1'b0;
        repeat (5 * S + 3) step();
        check("pre-reset slot5 anode", 32'(last_an), 32'hDF);
        check("pre-reset slot5 cathode", 32'(last_cath), 32'h30);
        reset = 1'b1; step(); reset = 1'b0;
        check("mid reset anode", 32'(last_an), 32'hFF);
        check("mid reset cathode", 32'(last_cath), 32'h7F);
        check("mid reset dp", 32'(last_dp), 32'h1);
        data = 32'h0000_00A5;
        load = 1'b1; step(); load = 1'b0;
        wait_fd("after reset", n);
        check("after reset frame_done clock", 32'(n + 1), 32'(FR));
        step();
        check("after reset digit0 anode", 32'(last_an), 32'hFE);
        check("after reset digit0 cathode", 32'(last_cath), 32'h12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
